// File: rtl/spi_controller.sv
// spi_controller: Wishbone B4 classic slave bridging to a mode-0, MSB-first, 8-bit SPI master.
// Registers: 0 DATA (tx/rx byte), 1 STATUS {rx_valid, busy}, 2 DIV (SCLK half-period = DIV+1), 3 unmapped.
module spi_controller #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int DEFAULT_DIV = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  CYC,
    input  logic                  STB,
    input  logic                  WE,
    input  logic [ADDR_WIDTH-1:0] ADR,
    input  logic [DATA_WIDTH-1:0] DAT_O,
    output logic [DATA_WIDTH-1:0] DAT_I,
    output logic                  ACK,
    output logic                  ERR,
    output logic                  SCLK,
    output logic                  MOSI,
    input  logic                  MISO,
    output logic                  CS
);
    typedef enum logic [2:0] {IDLE, LEAD, HIGH, LOW, DONE} state_t;
    state_t state_q, state_d;
    logic [7:0] cnt_q, cnt_d, fdiv_q, fdiv_d, div_q, div_d, sh_q, sh_d, rx_q, rx_d;
    logic [3:0] bit_q, bit_d;
    logic rx_valid_q, rx_valid_d, sclk_q, sclk_d, mosi_q, mosi_d, cs_q, cs_d;
    logic ack_q, ack_d, err_q, err_d;
    logic [DATA_WIDTH-1:0] dat_q, dat_d;
    logic [1:0] sel;
    logic req, busy, acc, start, rd_acc, unused;

    assign sel    = ADR[3:2];
    assign unused = &{1'b0, ADR[ADDR_WIDTH-1:4], ADR[1:0], DAT_O[DATA_WIDTH-1:8]};
    assign req    = CYC & STB;
    assign busy   = state_q inside {LEAD, HIGH, LOW};
    // A DATA write during a frame is held off (no ACK) until the shifter is free.
    assign acc    = req & ~ack_q & ~err_q & ~(WE & (sel == 2'd0) & busy);
    assign start  = acc & WE & (sel == 2'd0);
    assign rd_acc = acc & ~WE;

    always_comb begin
        ack_d      = req & (ack_q | (acc & (sel != 2'd3)));
        err_d      = req & (err_q | (acc & (sel == 2'd3)));
        dat_d      = !rd_acc ? dat_q :
                     sel == 2'd0 ? DATA_WIDTH'(rx_q) :
                     sel == 2'd1 ? DATA_WIDTH'({rx_valid_q, busy}) :
                     sel == 2'd2 ? DATA_WIDTH'(div_q) : '0;
        div_d      = (acc & WE & (sel == 2'd2)) ? DAT_O[7:0] : div_q;
        rx_valid_d = rx_valid_q & ~(rd_acc & (sel == 2'd0));
        state_d    = state_q;
        cnt_d      = cnt_q;
        fdiv_d     = fdiv_q;
        sh_d       = sh_q;
        rx_d       = rx_q;
        bit_d      = bit_q;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        cs_d       = cs_q;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    state_d = LEAD;
                    sh_d    = DAT_O[7:0];
                    mosi_d  = DAT_O[7];
                    cs_d    = 1'b0;
                    bit_d   = 4'd0;
                    cnt_d   = div_q;
                    fdiv_d  = div_q;
                end
            end
            LEAD, LOW: begin
                if (state_q == LOW && bit_q == 4'd8) begin
                    state_d    = DONE;
                    rx_d       = sh_q;
                    rx_valid_d = 1'b1;
                    cs_d       = 1'b1;
                    mosi_d     = 1'b0;
                end else if (cnt_q == 8'd0) begin
                    // Rising edge: sample MISO into the LSB as the shifter moves up.
                    state_d = HIGH;
                    sclk_d  = 1'b1;
                    sh_d    = {sh_q[6:0], MISO};
                    cnt_d   = fdiv_q;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            HIGH: begin
                if (cnt_q == 8'd0) begin
                    state_d = LOW;
                    sclk_d  = 1'b0;
                    mosi_d  = (bit_q != 4'd7) & sh_q[7];
                    bit_d   = bit_q + 4'd1;
                    cnt_d   = fdiv_q;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            fdiv_q     <= '0;
            div_q      <= 8'(DEFAULT_DIV);
            sh_q       <= '0;
            rx_q       <= '0;
            bit_q      <= '0;
            rx_valid_q <= 1'b0;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            cs_q       <= 1'b1;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            dat_q      <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            fdiv_q     <= fdiv_d;
            div_q      <= div_d;
            sh_q       <= sh_d;
            rx_q       <= rx_d;
            bit_q      <= bit_d;
            rx_valid_q <= rx_valid_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            cs_q       <= cs_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            dat_q      <= dat_d;
        end
    end

    assign DAT_I = dat_q;
    assign ACK   = ack_q;
    assign ERR   = err_q;
    assign SCLK  = sclk_q;
    assign MOSI  = mosi_q;
    assign CS    = cs_q;
endmodule

// File: tb/tb_spi_controller.sv
// tb_spi_controller: directed and randomized checks of the Wishbone-to-SPI bridge.
// A behavioural SPI slave and bus monitor supply the expected bytes, edge counts and SCLK phase lengths.
module tb_spi_controller;
    logic clk = 1'b0, rst = 1'b1, CYC = 1'b0, STB = 1'b0, WE = 1'b0;
    logic MISO, ACK, ERR, SCLK, MOSI, CS;
    logic [31:0] ADR = '0, DAT_O = '0, DAT_I;
    int total = 0, bad = 0;

    always #5 clk = ~clk;

    spi_controller #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEFAULT_DIV(4)) dut (
        .clk(clk), .rst(rst), .CYC(CYC), .STB(STB), .WE(WE), .ADR(ADR), .DAT_O(DAT_O),
        .DAT_I(DAT_I), .ACK(ACK), .ERR(ERR), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO), .CS(CS)
    );

    // Slave model: presents bit 7 when CS falls, next bit after every SCLK fall.
    logic loop = 1'b1;
    logic [7:0] sbyte = '0, mosi_bits = '0;
    int sidx = -1, rises = 0, frames = 0, hi_cnt = 0, hi_min = 1000, hi_max = 0;
    logic sclk_p = 1'b0, cs_p = 1'b1;
    assign MISO = loop ? MOSI : (sidx >= 0 ? sbyte[sidx[2:0]] : 1'b0);

    always @(negedge clk) begin
        if (SCLK && !sclk_p) begin
            rises++;
            mosi_bits = {mosi_bits[6:0], MOSI};
        end
        if (SCLK) hi_cnt++;
        if (!SCLK && sclk_p) begin
            hi_min = hi_cnt < hi_min ? hi_cnt : hi_min;
            hi_max = hi_cnt > hi_max ? hi_cnt : hi_max;
            hi_cnt = 0;
            sidx--;
        end
        if (!CS && cs_p) begin
            frames++;
            sidx = 7;
        end
        sclk_p = SCLK;
        cs_p = CS;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic wb(input logic we, input logic [3:0] a, input logic [31:0] wd,
                      output logic [31:0] rdat, output logic ak, output logic er, output int waits);
        @(negedge clk);
        CYC = 1'b1; STB = 1'b1; WE = we; ADR = {28'h0, a}; DAT_O = wd;
        waits = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (ACK || ERR) break;
            waits++;
        end
        ak = ACK; er = ERR; rdat = DAT_I;
        chk("ack_err_excl", {31'h0, ACK & ERR}, 32'h0);
        CYC = 1'b0; STB = 1'b0; WE = 1'b0;
    endtask

    logic [31:0] rd, st0, dv0;
    logic ak, er;
    int w, r0, f0, acks, stalls;
    logic [7:0] tx, sb;
    logic [1:0] d;

    task automatic wait_idle();
        for (int i = 0; i < 500; i++) begin
            wb(1'b0, 4'h4, 32'h0, rd, ak, er, w);
            if (!rd[0]) break;
        end
    endtask

    task automatic stats_clear();
        hi_min = 1000; hi_max = 0; hi_cnt = 0; r0 = rises;
    endtask

    initial begin
        // Reset
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_cs", {31'h0, CS}, 32'h1);
        chk("rst_sclk", {31'h0, SCLK}, 32'h0);
        chk("rst_mosi", {31'h0, MOSI}, 32'h0);
        chk("rst_ack", {31'h0, ACK}, 32'h0);
        chk("rst_err", {31'h0, ERR}, 32'h0);
        chk("rst_dat", DAT_I, 32'h0);
        wb(1'b0, 4'h4, 32'h0, rd, ak, er, w);
        chk("rst_status", rd, 32'h0);
        chk("rst_status_ack", {31'h0, ak}, 32'h1);
        wb(1'b0, 4'h8, 32'h0, rd, ak, er, w);
        chk("rst_div", rd, 32'h4);

        // Loopback 0xA5
        loop = 1'b1;
        stats_clear();
        wb(1'b1, 4'h0, 32'hA5, rd, ak, er, w);
        chk("lb_ack", {31'h0, ak}, 32'h1);
        @(negedge clk);
        chk("lb_ack_drop", {31'h0, ACK}, 32'h0);
        wait_idle();
        chk("lb_status_done", rd, 32'h2);
        chk("lb_rises", rises - r0, 8);
        chk("lb_mosi_seq", {24'h0, mosi_bits}, 32'hA5);
        chk("lb_hi_len", hi_max, 5);
        wb(1'b0, 4'h0, 32'h0, rd, ak, er, w);
        chk("lb_data", rd, 32'hA5);
        wb(1'b0, 4'h4, 32'h0, rd, ak, er, w);
        chk("lb_status_clr", rd, 32'h0);

        // Back-to-back sweep 0x00..0xFE
        f0 = frames; acks = 0; stalls = 0;
        for (int i = 0; i < 255; i++) begin
            wb(1'b1, 4'h0, 32'(i), rd, ak, er, w);
            acks += int'(ak);
            stalls += int'(w > 0);
        end
        wait_idle();
        chk("sweep_acks", acks, 255);
        chk("sweep_stalls", stalls, 254);
        chk("sweep_frames", frames - f0, 255);
        wb(1'b0, 4'h0, 32'h0, rd, ak, er, w);
        chk("sweep_last", rd, 32'hFE);

        // Divider 0, loopback 0x3C
        wb(1'b1, 4'h8, 32'h0, rd, ak, er, w);
        wb(1'b0, 4'h8, 32'h0, rd, ak, er, w);
        chk("div0_read", rd, 32'h0);
        stats_clear();
        wb(1'b1, 4'h0, 32'h3C, rd, ak, er, w);
        wait_idle();
        chk("div0_hi_min", hi_min, 1);
        chk("div0_hi_max", hi_max, 1);
        chk("div0_rises", rises - r0, 8);
        wb(1'b0, 4'h0, 32'h0, rd, ak, er, w);
        chk("div0_data", rd, 32'h3C);

        // Divider 9 with an independent slave byte
        wb(1'b1, 4'h8, 32'h9, rd, ak, er, w);
        loop = 1'b0; sbyte = 8'h96;
        stats_clear();
        wb(1'b1, 4'h0, 32'h4B, rd, ak, er, w);
        wait_idle();
        chk("div9_hi_min", hi_min, 10);
        chk("div9_hi_max", hi_max, 10);
        chk("div9_mosi", {24'h0, mosi_bits}, 32'h4B);
        wb(1'b0, 4'h0, 32'h0, rd, ak, er, w);
        chk("div9_data", rd, 32'h96);

        // DIV written mid-frame only affects the following frame
        loop = 1'b1;
        stats_clear();
        wb(1'b1, 4'h0, 32'h5A, rd, ak, er, w);
        wb(1'b1, 4'h8, 32'h2, rd, ak, er, w);
        chk("divmid_nostall", w, 0);
        wait_idle();
        chk("divmid_old_hi", hi_max, 10);
        stats_clear();
        wb(1'b1, 4'h0, 32'h11, rd, ak, er, w);
        wait_idle();
        chk("divmid_new_hi", hi_max, 3);

        // Randomized frames against the slave model
        loop = 1'b0;
        for (int k = 0; k < 6; k++) begin
            d = 2'($urandom_range(0, 3));
            tx = 8'($urandom);
            sb = 8'($urandom);
            sbyte = sb;
            wb(1'b1, 4'h8, {30'h0, d}, rd, ak, er, w);
            stats_clear();
            wb(1'b1, 4'h0, {24'h0, tx}, rd, ak, er, w);
            wait_idle();
            chk("rnd_mosi", {24'h0, mosi_bits}, {24'h0, tx});
            chk("rnd_rises", rises - r0, 8);
            chk("rnd_hi", hi_max, int'(d) + 1);
            wb(1'b0, 4'h0, 32'h0, rd, ak, er, w);
            chk("rnd_rx", rd, {24'h0, sb});
        end

        // Unread RX byte is overwritten, rx_valid stays set
        sbyte = 8'hC3;
        wb(1'b1, 4'h0, 32'h01, rd, ak, er, w);
        wait_idle();
        sbyte = 8'h3E;
        wb(1'b1, 4'h0, 32'h02, rd, ak, er, w);
        wait_idle();
        chk("ovw_status", rd, 32'h2);
        wb(1'b0, 4'h0, 32'h0, rd, ak, er, w);
        chk("ovw_data", rd, 32'h3E);

        // Unmapped address and ignored STATUS write
        wb(1'b1, 4'h8, 32'h1, rd, ak, er, w);
        wb(1'b0, 4'h4, 32'h0, rd, ak, er, w);
        st0 = rd;
        wb(1'b0, 4'h8, 32'h0, rd, ak, er, w);
        dv0 = rd;
        wb(1'b0, 4'hC, 32'h0, rd, ak, er, w);
        chk("err_rd_err", {31'h0, er}, 32'h1);
        chk("err_rd_ack", {31'h0, ak}, 32'h0);
        @(negedge clk);
        chk("err_drop", {31'h0, ERR}, 32'h0);
        wb(1'b1, 4'hC, 32'h55, rd, ak, er, w);
        chk("err_wr_err", {31'h0, er}, 32'h1);
        chk("err_wr_ack", {31'h0, ak}, 32'h0);
        wb(1'b1, 4'h4, 32'h3, rd, ak, er, w);
        chk("st_wr_ack", {31'h0, ak}, 32'h1);
        wb(1'b0, 4'h8, 32'h0, rd, ak, er, w);
        chk("err_div_kept", rd, dv0);
        wb(1'b0, 4'h4, 32'h0, rd, ak, er, w);
        chk("err_status_kept", rd, st0);

        // Reset after 3 SCLK rises; leave an unread byte first so rx_valid is set
        sbyte = 8'h77;
        wb(1'b1, 4'h0, 32'h0F, rd, ak, er, w);
        wait_idle();
        r0 = rises;
        wb(1'b1, 4'h0, 32'hF0, rd, ak, er, w);
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (rises - r0 >= 3) break;
        end
        chk("mid_rises", rises - r0, 3);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_cs", {31'h0, CS}, 32'h1);
        chk("mid_sclk", {31'h0, SCLK}, 32'h0);
        rst = 1'b0;
        wb(1'b0, 4'h4, 32'h0, rd, ak, er, w);
        chk("mid_status", rd, 32'h0);
        wb(1'b0, 4'h0, 32'h0, rd, ak, er, w);
        chk("mid_rx", rd, 32'h0);
        wb(1'b0, 4'h8, 32'h0, rd, ak, er, w);
        chk("mid_div", rd, 32'h4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/spi_controller.md
Name: spi_controller

Overview:
- Wishbone B4 slave (classic, single-beat) to SPI master bridge.
- Each CPU write to the TX data register shifts one byte out on MOSI and simultaneously captures one byte from MISO into the RX data register.
- SPI mode 0, MSB first, 8-bit frames.
- Programmable SCLK divider; single active-low chip select driven automatically per frame.

Parameters:
- DATA_WIDTH, 32: Wishbone data width.
- ADDR_WIDTH, 32: Wishbone address width.
- DEFAULT_DIV, 4: reset value of the clock-divider register.

Ports:
- clk  in  1  single system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- CYC  in  1  Wishbone cycle.
- STB  in  1  Wishbone strobe.
- WE  in  1  Wishbone write enable.
- ADR  in  ADDR_WIDTH  byte address; only ADR[3:2] decoded.
- DAT_O  in  DATA_WIDTH  master write data (the WB4 interface field carrying master-to-slave data).
- DAT_I  out  DATA_WIDTH  read data to master.
- ACK  out  1  transfer acknowledge.
- ERR  out  1  bus error.
- SCLK  out  1  SPI clock.
- MOSI  out  1  SPI data out.
- MISO  in  1  SPI data in.
- CS  out  1  chip select, active low.

Port grouping: Wishbone signals are bundled in the WB4 interface (clk, rst carried by it); SPI signals are bundled in the SPI interface.

Behaviour:

Register map (ADR[3:2]):
- 0 DATA
  - Write: bits[7:0] loaded to TX shifter; starts a frame.
  - Read: {24'b0, RX byte}; clears rx_valid.
- 1 STATUS (read only): bit0 busy, bit1 rx_valid, others 0.
- 2 DIV (read/write): bits[7:0]; SCLK half-period = DIV+1 clk cycles.
- 3: unmapped → ERR pulse, no ACK.
- Writes to STATUS are ignored but ACKed.

Wishbone handshake:
- Request = CYC & STB.
- ACK is registered: asserted the cycle after the request is accepted, held while CYC & STB stay high, cleared the cycle after STB drops.
- Exactly one register side effect per request (no repeat while ACK held).
- Write to DATA while busy: wait state; ACK withheld until the current frame ends, then the write is accepted.
- ERR follows the same timing rules as ACK; ACK and ERR are never both high.
- DAT_I is valid whenever ACK is high for a read.

Reset values:
- ACK=0, ERR=0, DAT_I=0.
- SCLK=0, MOSI=0, CS=1.
- busy=0, rx_valid=0, RX=0, DIV=DEFAULT_DIV.
- Reset mid-frame aborts the frame immediately: CS=1, no RX update.

State machine:
- IDLE:
  - CS=1, SCLK=0.
  - On accepted DATA write: load shifter, bit counter=0, MOSI=bit7, CS=0, busy=1, go to LEAD.
- LEAD:
  - Wait DIV+1 cycles (CS-to-first-edge setup).
  - Go to HIGH with SCLK rising.
- HIGH:
  - On SCLK rise, sample MISO into shifter LSB.
  - After DIV+1 cycles, drop SCLK, go to LOW.
- LOW:
  - If 8 bits are done, go to DONE.
  - Otherwise shift left, drive the next bit on MOSI, wait DIV+1 cycles, go to HIGH.
- DONE:
  - RX = shifter, rx_valid=1, CS=1, busy=0, MOSI=0.
  - Return to IDLE next cycle.

Timing and counts:
- Frame length: (17×(DIV+1))+2 clk cycles (approx.).
- Exactly 8 SCLK rising edges per frame.
- SCLK is idle-low; CS never glitches within a frame.
- A new RX byte overwrites an unread one (rx_valid stays 1).
- DIV=0 is legal: half-period = 1 cycle.
- A DIV write during a frame takes effect on the next frame.

Test Plan:
1. Reset:
   - Stimulus: rst high 2 cycles.
   - Required: CS=1, SCLK=0, ACK=0, ERR=0; STATUS reads 0; DIV reads 4.
2. Loopback byte:
   - Stimulus: MISO tied to MOSI; write 0xA5 to addr 0; poll STATUS until busy=0.
   - Required: 8 SCLK rises; MOSI bit sequence 1,0,1,0,0,1,0,1; STATUS=0x2; DATA reads 0xA5; STATUS afterwards 0x0.
3. Back-to-back sweep:
   - Stimulus: loopback; write bytes 0x00..0xFE to addr 0 consecutively with no polling.
   - Required: each write stalls until the previous frame ends; every write is ACKed exactly once; 255 frames; final DATA read 0xFE.
4. Divider:
   - Stimulus: write DIV=0, then send 0x3C.
   - Required: SCLK half-period 1 cycle; received 0x3C. With DIV=9: half-period 10 cycles.
5. Bus error:
   - Stimulus: read or write addr 0xC.
   - Required: ERR for one request, ACK=0, no state change.
6. Reset mid-frame:
   - Stimulus: assert rst after 3 SCLK rises.
   - Required: next cycle CS=1, SCLK=0, busy=0, rx_valid=0.
